// File: rtl/xor_nor_seq_if.sv
// Handshake and data bundle for the NOR-built sequential bitwise/parity unit.
// The master launches an operation; the slave reports busy/done and the committed result.
interface xor_nor_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             parity;

    modport master (
        output start, mode, a, b,
        input  busy, done, y, parity
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, y, parity
    );
endinterface

// File: rtl/xor_nor_seq.sv
// Sequential XOR/XNOR/NOR/OR unit: CHUNK bits per cycle, LSB-first, datapath built from 2-input
// NOR cells only, plus a running parity of the result word.
module xor_nor_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic          clk,
    input  logic          reset,
    xor_nor_seq_if.slave  bus
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // The only primitive the datapath is allowed: a 2-input NOR.
    function automatic logic nor2(input logic x, input logic y);
        return ~x & ~y;
    endfunction

    function automatic logic nor_xor(input logic x, input logic y);
        logic nx, ny, t1, t2, xn;
        nx = nor2(x, x);
        ny = nor2(y, y);
        t1 = nor2(y, nx);
        t2 = nor2(x, ny);
        xn = nor2(t1, t2);
        return nor2(xn, xn);
    endfunction

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_y;
    logic [WIDTH-1:0] w_a_d, w_b_d, w_acc_d, w_y_d, w_acc_sh;
    logic [3:0]       r_en_n, w_en_n_d, w_en_n_ld;
    logic [CW-1:0]    r_cnt, w_cnt_d;
    logic             r_par, w_par_d, r_parity, w_parity_d, w_par_next;
    logic [CHUNK-1:0] w_res;

    // Active-low one-hot enables let each mode select be a single NOR against the inverted term.
    always_comb begin
        w_en_n_ld = 4'b1111;
        unique case (bus.mode)
            2'b00:   w_en_n_ld = 4'b1110;
            2'b01:   w_en_n_ld = 4'b1101;
            2'b10:   w_en_n_ld = 4'b1011;
            2'b11:   w_en_n_ld = 4'b0111;
            default: w_en_n_ld = 4'b1111;
        endcase
    end

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
        logic w_na, w_nb, w_t1, w_t2, w_xnor, w_xor, w_nor, w_or;
        logic w_s0, w_s1, w_s2, w_s3, w_u, w_v, w_uv;

        assign w_na   = nor2(r_a[gi], r_a[gi]);
        assign w_nb   = nor2(r_b[gi], r_b[gi]);
        assign w_t1   = nor2(r_b[gi], w_na);
        assign w_t2   = nor2(r_a[gi], w_nb);
        assign w_xnor = nor2(w_t1, w_t2);
        assign w_xor  = nor2(w_xnor, w_xnor);
        assign w_nor  = nor2(r_a[gi], r_b[gi]);
        assign w_or   = nor2(w_nor, w_nor);

        // sel = en AND f = nor(en_n, ~f); each function's complement is already available.
        assign w_s0 = nor2(r_en_n[0], w_xnor);
        assign w_s1 = nor2(r_en_n[1], w_xor);
        assign w_s2 = nor2(r_en_n[2], w_or);
        assign w_s3 = nor2(r_en_n[3], w_nor);

        assign w_u  = nor2(w_s0, w_s1);
        assign w_v  = nor2(w_s2, w_s3);
        assign w_uv = nor2(nor2(w_u, w_u), nor2(w_v, w_v));
        assign w_res[gi] = nor2(w_uv, w_uv);
    end

    always_comb begin
        w_par_next = r_par;
        for (int i = 0; i < CHUNK; i++) begin
            w_par_next = nor_xor(w_par_next, w_res[i]);
        end
    end

    assign w_acc_sh = WIDTH'({w_res, r_acc} >> CHUNK);

    always_comb begin
        w_state_d  = r_state;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_en_n_d   = r_en_n;
        w_acc_d    = r_acc;
        w_cnt_d    = r_cnt;
        w_par_d    = r_par;
        w_y_d      = r_y;
        w_parity_d = r_parity;
        unique case (r_state)
            StIdle, StDone: begin
                w_state_d = StIdle;
                if (bus.start) begin
                    w_a_d     = bus.a;
                    w_b_d     = bus.b;
                    w_en_n_d  = w_en_n_ld;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_par_d   = 1'b0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_a_d   = r_a >> CHUNK;
                w_b_d   = r_b >> CHUNK;
                w_acc_d = w_acc_sh;
                w_par_d = w_par_next;
                w_cnt_d = r_cnt + CW'(1);
                if (r_cnt == CW'(N - 1)) begin
                    w_state_d  = StDone;
                    w_y_d      = w_acc_sh;
                    w_parity_d = w_par_next;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_en_n   <= 4'b1111;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_par    <= 1'b0;
            r_y      <= '0;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_en_n   <= w_en_n_d;
            r_acc    <= w_acc_d;
            r_cnt    <= w_cnt_d;
            r_par    <= w_par_d;
            r_y      <= w_y_d;
            r_parity <= w_parity_d;
        end
    end

    assign bus.busy   = (r_state == StRun);
    assign bus.done   = (r_state == StDone);
    assign bus.y      = r_y;
    assign bus.parity = r_parity;
endmodule

// File: tb/tb_xor_nor_seq.sv
// Scoreboard bench for xor_nor_seq: 8/1, 8/4 and 2/1 instances sharing clock and reset.
// Expected results are queued at launch and popped when done pulses.
module tb_xor_nor_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xor_nor_seq_if #(.WIDTH(8)) if8 ();
    xor_nor_seq_if #(.WIDTH(8)) if84 ();
    xor_nor_seq_if #(.WIDTH(2)) if2 ();

    xor_nor_seq #(.WIDTH(8), .CHUNK(1)) dut8  (.clk(clk), .reset(reset), .bus(if8));
    xor_nor_seq #(.WIDTH(8), .CHUNK(4)) dut84 (.clk(clk), .reset(reset), .bus(if84));
    xor_nor_seq #(.WIDTH(2), .CHUNK(1)) dut2  (.clk(clk), .reset(reset), .bus(if2));

    typedef struct packed {
        logic [7:0] y;
        logic       par;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q2[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] m, input int w);
        exp_t e;
        logic [7:0] r;
        case (m)
            2'b00:   r = a ^ b;
            2'b01:   r = ~(a ^ b);
            2'b10:   r = ~(a | b);
            default: r = a | b;
        endcase
        for (int i = 0; i < 8; i++) if (i >= w) r[i] = 1'b0;
        e.y   = r;
        e.par = ^r;
        return e;
    endfunction

    // Drive start for one sampled edge, queue the expectation, then scramble the operands.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                           input logic [7:0] ey, input logic ep, input bit push);
        exp_t e;
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = a;
        if8.b = b;
        if8.mode = m;
        e.y = ey;
        e.par = ep;
        if (push) q8.push_back(e);
        @(negedge clk);
        if8.start = 1'b0;
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        if8.mode = 2'($urandom);
    endtask

    // Called just after the start-sampling edge; returns the cycle count to done (-1 on timeout).
    task automatic wait_done8(output int cyc, output bit busy_ok, output bit y_stable);
        logic [7:0] y0;
        y0 = if8.y;
        cyc = 0;
        busy_ok = 1'b1;
        y_stable = 1'b1;
        while (if8.done !== 1'b1 && cyc < 40) begin
            if (if8.busy !== 1'b1) busy_ok = 1'b0;
            if (if8.y !== y0) y_stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (if8.done !== 1'b1) cyc = -1;
        else if (if8.busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec += 4;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", if8.busy); end
        if (if8.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", if8.done); end
        if (if8.y !== 8'h00) begin n_err++; $display("FAIL reset_y: got %h want 00", if8.y); end
        if (if8.parity !== 1'b0) begin
            n_err++; $display("FAIL reset_parity: got %b want 0", if8.parity);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0/0", if8.busy, if8.done);
        end
    endtask

    task automatic test_modes();
        logic [7:0] ta[5] = '{8'hA5, 8'hA5, 8'hF0, 8'hA5, 8'hA5};
        logic [7:0] tb[5] = '{8'h0F, 8'h0F, 8'h01, 8'h0F, 8'h0F};
        logic [1:0] tm[5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [7:0] ty[5] = '{8'hAA, 8'h55, 8'hF1, 8'h50, 8'hAF};
        logic       tp[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int cyc;
        bit bok, yst;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            launch8(ta[i], tb[i], tm[i], ty[i], tp[i], 1'b1);
            wait_done8(cyc, bok, yst);
            e = q8.pop_front();
            n_vec += 6;
            if (cyc !== 8) begin n_err++; $display("FAIL mode%0d_latency: got %0d want 8", i, cyc); end
            if (!bok) begin n_err++; $display("FAIL mode%0d_busy: got busy wrong want 1 in RUN/0 at done", i); end
            if (!yst) begin n_err++; $display("FAIL mode%0d_y_hold: got y changed before commit want held", i); end
            if (if8.y !== e.y) begin n_err++; $display("FAIL mode%0d_y: got %h want %h", i, if8.y, e.y); end
            if (if8.parity !== e.par) begin
                n_err++; $display("FAIL mode%0d_parity: got %b want %b", i, if8.parity, e.par);
            end
            @(negedge clk);
            if (if8.done !== 1'b0 || if8.y !== e.y) begin
                n_err++; $display("FAIL mode%0d_after: got done=%b y=%h want 0/%h", i, if8.done, if8.y, e.y);
            end
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit bok, yst;
        exp_t e;
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = 8'hA5;
        if8.b = 8'h0F;
        if8.mode = 2'b00;
        q8.push_back('{y: 8'hAA, par: 1'b0});
        @(negedge clk);
        if8.a = 8'h33;
        if8.b = 8'hFF;
        if8.mode = 2'b11;
        wait_done8(cyc, bok, yst);
        if8.start = 1'b0;
        e = q8.pop_front();
        n_vec += 4;
        if (cyc !== 8) begin n_err++; $display("FAIL hold_latency: got %0d want 8", cyc); end
        if (if8.y !== e.y) begin n_err++; $display("FAIL hold_y: got %h want %h", if8.y, e.y); end
        if (if8.parity !== e.par) begin
            n_err++; $display("FAIL hold_parity: got %b want %b", if8.parity, e.par);
        end
        @(negedge clk);
        if (if8.done !== 1'b0 || if8.busy !== 1'b0) begin
            n_err++; $display("FAIL hold_after: got done=%b busy=%b want 0/0", if8.done, if8.busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit bok, yst;
        exp_t e;
        launch8(8'hA5, 8'h0F, 2'b00, 8'hAA, 1'b0, 1'b1);
        wait_done8(cyc, bok, yst);
        e = q8.pop_front();
        n_vec += 2;
        if (cyc !== 8 || if8.y !== e.y) begin
            n_err++; $display("FAIL b2b_first: got lat=%0d y=%h want 8/%h", cyc, if8.y, e.y);
        end
        if8.start = 1'b1;
        if8.a = 8'hFF;
        if8.b = 8'h00;
        if8.mode = 2'b00;
        q8.push_back('{y: 8'hFF, par: 1'b0});
        @(negedge clk);
        if8.start = 1'b0;
        if8.a = 8'h00;
        if (if8.busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_idle: got busy=%b want 1", if8.busy); end
        wait_done8(cyc, bok, yst);
        e = q8.pop_front();
        n_vec += 4;
        if (cyc !== 8) begin n_err++; $display("FAIL b2b_latency: got %0d want 8", cyc); end
        if (!yst) begin n_err++; $display("FAIL b2b_y_hold: got y changed before commit want held"); end
        if (if8.y !== e.y) begin n_err++; $display("FAIL b2b_y: got %h want %h", if8.y, e.y); end
        if (if8.parity !== e.par) begin
            n_err++; $display("FAIL b2b_parity: got %b want %b", if8.parity, e.par);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        launch8(8'h5A, 8'h0F, 2'b00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec += 4;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", if8.busy); end
        if (if8.done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", if8.done); end
        if (if8.y !== 8'h00) begin n_err++; $display("FAIL midrst_y: got %h want 00", if8.y); end
        if (if8.parity !== 1'b0) begin
            n_err++; $display("FAIL midrst_parity: got %b want 0", if8.parity);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.done === 1'b1 || if8.busy === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 0) begin n_err++; $display("FAIL midrst_quiet: got %0d active cycles want 0", dones); end
    endtask

    task automatic test_chunk4();
        int cyc;
        exp_t e;
        @(negedge clk);
        if84.start = 1'b1;
        if84.a = 8'h3C;
        if84.b = 8'hC3;
        if84.mode = 2'b00;
        q4.push_back('{y: 8'hFF, par: 1'b0});
        @(negedge clk);
        if84.start = 1'b0;
        if84.a = 8'h00;
        cyc = 0;
        while (if84.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (if84.done !== 1'b1) cyc = -1;
        e = q4.pop_front();
        n_vec += 3;
        if (cyc !== 2) begin n_err++; $display("FAIL chunk4_latency: got %0d want 2", cyc); end
        if (if84.y !== e.y) begin n_err++; $display("FAIL chunk4_y: got %h want %h", if84.y, e.y); end
        if (if84.parity !== e.par) begin
            n_err++; $display("FAIL chunk4_parity: got %b want %b", if84.parity, e.par);
        end
    endtask

    task automatic test_sweep2();
        int cyc;
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    @(negedge clk);
                    if2.start = 1'b1;
                    if2.a = 2'(a);
                    if2.b = 2'(b);
                    if2.mode = 2'(m);
                    q2.push_back(model(8'(a), 8'(b), 2'(m), 2));
                    @(negedge clk);
                    if2.start = 1'b0;
                    if2.a = ~2'(a);
                    cyc = 0;
                    while (if2.done !== 1'b1 && cyc < 20) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (if2.done !== 1'b1) cyc = -1;
                    e = q2.pop_front();
                    n_vec += 3;
                    if (cyc !== 2) begin
                        n_err++; $display("FAIL sweep_m%0d_a%0d_b%0d_latency: got %0d want 2", m, a, b, cyc);
                    end
                    if (if2.y !== e.y[1:0]) begin
                        n_err++;
                        $display("FAIL sweep_m%0d_a%0d_b%0d_y: got %h want %h", m, a, b, if2.y, e.y[1:0]);
                    end
                    if (if2.parity !== e.par) begin
                        n_err++;
                        $display("FAIL sweep_m%0d_a%0d_b%0d_parity: got %b want %b", m, a, b,
                                 if2.parity, e.par);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.mode = '0;
        if84.start = 1'b0; if84.a = '0; if84.b = '0; if84.mode = '0;
        if2.start = 1'b0;  if2.a = '0;  if2.b = '0;  if2.mode = '0;
        test_reset();
        test_modes();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_chunk4();
        test_sweep2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1);
    end
endmodule
